// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM encoding,
// fault codes, access sizes and the funct3 unsigned-load bit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL    = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT    = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int unsigned FUNCT3_UNSIGNED_BIT = 2;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// load lane extraction with sign/zero extension, and access legality.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] lane;

    always_comb begin
        lane        = rdata_word >> {offset, 3'b000};
        be          = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = lane;
        misaligned  = 1'b0;
        illegal     = 1'b0;

        case (size)
            SIZE_B: begin
                be          = 4'b0001 << offset;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_unsigned ? {24'b0, lane[7:0]}
                                          : {{24{lane[7]}}, lane[7:0]};
            end
            SIZE_H: begin
                be          = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_unsigned ? {16'b0, lane[15:0]}
                                          : {{16{lane[15]}}, lane[15:0]};
                misaligned  = offset[0];
            end
            SIZE_W: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = lane;
                misaligned  = (offset != 2'b00);
                // An unsigned word (funct3 110) has no meaning in RV32I.
                illegal     = is_unsigned;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one load or store per start over a
// req/ack word bus, with misalignment, illegal-funct3 and timeout faults.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_lanes_q, wdata_lanes_d;
    logic [3:0]  be_q, be_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;

    logic        in_idle;
    logic [1:0]  al_size;
    logic        al_unsigned;
    logic [1:0]  al_offset;
    logic [3:0]  al_be;
    logic [31:0] al_wdata_lanes;
    logic [31:0] al_rdata_ext;
    logic        al_misaligned;
    logic        al_illegal;

    // One aligner serves both phases: in IDLE it classifies the incoming
    // request, afterwards it extracts load data using the latched access.
    assign in_idle     = (state_q == ST_IDLE);
    assign al_size     = in_idle ? funct3[1:0] : funct3_q[1:0];
    assign al_unsigned = in_idle ? funct3[FUNCT3_UNSIGNED_BIT]
                                 : funct3_q[FUNCT3_UNSIGNED_BIT];
    assign al_offset   = in_idle ? addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .offset      (al_offset),
        .wdata       (wdata),
        .rdata_word  (mem_rdata),
        .be          (al_be),
        .wdata_lanes (al_wdata_lanes),
        .rdata_ext   (al_rdata_ext),
        .misaligned  (al_misaligned),
        .illegal     (al_illegal)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_lanes_d = wdata_lanes_q;
        be_d          = be_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d     = we;
                    funct3_d = funct3;
                    addr_d   = addr;
                    cnt_d    = 8'd0;
                    // Stores have no unsigned form; illegal outranks misaligned.
                    if (al_illegal || (we && funct3[FUNCT3_UNSIGNED_BIT])) begin
                        state_d = ST_DONE;
                        fault_d = FAULT_ILLEGAL;
                    end else if (al_misaligned) begin
                        state_d = ST_DONE;
                        fault_d = FAULT_MISALIGNED;
                    end else begin
                        state_d       = ST_REQ;
                        be_d          = al_be;
                        wdata_lanes_d = al_wdata_lanes;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    fault_d = FAULT_NONE;
                    be_d    = 4'b0000;
                    if (!we_q) begin
                        rdata_d = al_rdata_ext;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_DONE;
                    fault_d = FAULT_TIMEOUT;
                    be_d    = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_q        <= 32'h0;
            wdata_lanes_q <= 32'h0;
            be_q          <= 4'b0000;
            cnt_q         <= 8'd0;
            rdata_q       <= 32'h0;
            fault_q       <= FAULT_NONE;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wdata_lanes_q <= wdata_lanes_d;
            be_q          <= be_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign fault     = fault_q;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_lanes_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a fault/rdata scoreboard queue.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_pass;
  int n_fail;
  int n_total;
  logic [33:0] exp_q[$];
  logic [31:0] model_rdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  model_load = {{24{b[7]}}, b};
      3'b100:  model_load = {24'h0, b};
      3'b001:  model_load = {{16{h[15]}}, h};
      3'b101:  model_load = {16'h0, h};
      default: model_load = w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] byte_be[4];
    byte_be[0] = 4'b0001;
    byte_be[1] = 4'b0010;
    byte_be[2] = 4'b0100;
    byte_be[3] = 4'b1000;
    if (sz == 2'b00) model_be = byte_be[off];
    else if (sz == 2'b01) model_be = off[1] ? 4'b1100 : 4'b0011;
    else model_be = 4'b1111;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) model_wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
    else if (sz == 2'b01) model_wd = {d[15:0], d[15:0]};
    else model_wd = d;
  endfunction

  function automatic logic [1:0] model_fault(input logic w, input logic [2:0] f3,
                                             input logic [1:0] off, input int ack_delay);
    if (f3[1:0] == 2'b11 || f3 == 3'b110 || (w && f3[2])) model_fault = 2'b10;
    else if ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00))
      model_fault = 2'b01;
    else if (ack_delay >= int'(TO)) model_fault = 2'b11;
    else model_fault = 2'b00;
  endfunction

  // driver: one access, bus responder with ack after ack_delay wait cycles
  task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word, input int ack_delay,
                           output int lat, output int nreq);
    logic [1:0]  ef;
    logic [31:0] er;
    logic [33:0] sb;
    ef = model_fault(w, f3, a[1:0], ack_delay);
    er = (!w && ef == 2'b00) ? model_load(f3, a[1:0], word) : model_rdata;
    model_rdata = er;
    exp_q.push_back({ef, er});

    we = w; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    tick();
    start = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7)); we = ~w;
    lat = 1;
    nreq = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (mem_req === 1'b1) begin
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_be", {28'h0, mem_be}, {28'h0, model_be(f3[1:0], a[1:0])});
        check("mem_wdata", mem_wdata, model_wd(f3[1:0], wd));
        check("mem_we", {31'h0, mem_we}, {31'h0, w});
        mem_ack = (nreq == ack_delay);
        mem_rdata = word;
        nreq++;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      lat++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    sb = exp_q.pop_front();
    if (done === 1'b1) begin
      check("fault", {30'h0, fault}, {30'h0, sb[33:32]});
      check("rdata", rdata, sb[31:0]);
      tick();
      check("done_one_cycle", {31'h0, done}, 32'h0);
    end
  endtask

  initial begin
    int lat;
    int nreq;
    int ndone;
    logic [2:0] ld_f3[5];
    logic [2:0] f3r;
    logic [1:0] offr;
    n_pass = 0; n_fail = 0; n_total = 0;
    model_rdata = 32'h0;
    reset_n = 1'b0; start = 1'b0; we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b100; ld_f3[2] = 3'b001;
    ld_f3[3] = 3'b101; ld_f3[4] = 3'b010;

    // reset state
    tick(); tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_fault", {30'h0, fault}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_ctrl", {28'h0, done, busy, mem_req, mem_we}, 32'h0);
    reset_n = 1'b1;
    tick();

    // lb at 0x103 with immediate ack
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, lat, nreq);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_latency", lat, 2);

    // lhu / lh at 0x202
    do_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_1234, 1, lat, nreq);
    check("lhu_rdata", rdata, 32'h0000_8001);
    do_access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, lat, nreq);
    check("lh_rdata", rdata, 32'hFFFF_8001);

    // sh at 0x306 with 3 wait cycles
    do_access(1'b1, 3'b001, 32'h0000_0306, 32'hDEAD_BEEF, 32'h1234_5678, 3, lat, nreq);
    check("sh_req_cycles", nreq, 4);
    check("sh_rdata_kept", rdata, 32'hFFFF_8001);

    // faults: misaligned, illegal size, unsigned store
    do_access(1'b0, 3'b010, 32'h0000_0401, 32'h0, 32'h0, 0, lat, nreq);
    check("misal_no_req", nreq, 0);
    do_access(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 0, lat, nreq);
    check("ill_no_req", nreq, 0);
    do_access(1'b1, 3'b100, 32'h0000_0401, 32'h55, 32'h0, 0, lat, nreq);
    check("ill_sb_no_req", nreq, 0);
    do_access(1'b0, 3'b110, 32'h0000_0400, 32'h0, 32'h0, 0, lat, nreq);

    // timeout, then ack landing in the timeout cycle
    do_access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 99, lat, nreq);
    check("to_req_cycles", nreq, 4);
    do_access(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'hCAFE_F00D, 3, lat, nreq);
    check("to_ack_wins", rdata, 32'hCAFE_F00D);

    // random legal loads
    for (int i = 0; i < 8; i++) begin
      f3r = ld_f3[$urandom_range(0, 4)];
      offr = 2'($urandom_range(0, 3));
      if (f3r[1:0] == 2'b01) offr[0] = 1'b0;
      if (f3r[1:0] == 2'b10) offr = 2'b00;
      do_access(1'b0, f3r, {20'h0, 10'($urandom_range(0, 1023)), offr}, 32'h0,
                $urandom, $urandom_range(0, 2), lat, nreq);
    end

    // reset in the middle of a request
    we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;
    model_rdata = 32'h0;
    tick();

    // start pulses while busy are dropped
    we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600; mem_rdata = 32'h1357_9BDF;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      start = busy;
      mem_ack = mem_req;
      if (done === 1'b1) ndone++;
      tick();
    end
    start = 1'b0; mem_ack = 1'b0;
    check("busy_start_dones", ndone, 1);
    check("busy_start_rdata", rdata, 32'h1357_9BDF);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
